// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter with bounded lock sharing one single-port data memory
// between two requesters, with registered read return and out-of-range error.
module data_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 128,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              g0, g1, any, we, lk, oor, owner;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // rr_q names the port that wins the next tie in ARB
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        owner   = (state_q == LOCK1);
        if (state_q == ARB) begin
            if (any) begin
                rr_d = ~g1;
                if (lk && LOCK_MAX > 1) begin
                    state_d = g1 ? LOCK1 : LOCK0;
                    cnt_d   = CW'(1);
                end
            end
        end else if (!any || !lk || cnt_q == CW'(LOCK_MAX - 1)) begin
            state_d = ARB;
            rr_d    = ~owner;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            case (state_q)
                LOCK0:   g0 = m0_req_i;
                LOCK1:   g1 = m1_req_i;
                default: begin
                    g0 = m0_req_i & (~m1_req_i | ~rr_q);
                    g1 = m1_req_i & (~m0_req_i | rr_q);
                end
            endcase
        end
    end

    assign any         = g0 | g1;
    assign addr        = g1 ? m1_addr_i : m0_addr_i;
    assign wdata       = g1 ? m1_wdata_i : m0_wdata_i;
    assign we          = g1 ? m1_we_i : m0_we_i;
    assign lk          = g1 ? m1_lock_i : m0_lock_i;
    assign oor         = {1'b0, addr} >= DEPTH_V;
    assign m0_gnt_o    = g0;
    assign m1_gnt_o    = g1;
    assign mem_addr_o  = any ? addr : '0;
    assign mem_wdata_o = any ? wdata : '0;
    assign mem_write_o = any & we & ~oor;
    assign mem_read_o  = any & ~we & ~oor;

    // out-of-range reads still complete with rvalid, but return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= g0 & ~we;
            rvalid1_q <= g1 & ~we;
            err0_q    <= g0 & oor;
            err1_q    <= g1 & oor;
            rdata0_q  <= (g0 & ~we & ~oor) ? mem_rdata_i : '0;
            rdata1_q  <= (g1 & ~we & ~oor) ? mem_rdata_i : '0;
        end
    end

    assign m0_rvalid_o = rvalid0_q;
    assign m1_rvalid_o = rvalid1_q;
    assign m0_err_o    = err0_q;
    assign m1_err_o    = err1_q;
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of reset, reads, writes, round-robin, lock bound,
// reset mid-lock and out-of-range handling against a behavioural 128x16 memory.
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;
    logic [15:0] mem [128];
    int          total = 0;
    int          bad = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
        .mem_read_o(mem_read), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[6:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[6:0]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0101);
        mem[12] = 16'h0055;
        {m0_we, m0_lock, m1_we, m1_lock} = '0;
        {m0_wdata, m1_wdata} = '0;
        rst_n = 1'b0;
        m0_req = 1'b1; m0_addr = 16'd12;
        m1_req = 1'b1; m1_addr = 16'd13;
        #3;
        chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
        chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        tick;
        rst_n = 1'b1;
        #1;
        chk("first_gnt", {m0_gnt, m1_gnt}, 2'b10);
        chk("first_mem_read", mem_read, 1'b1);
        chk("first_addr", mem_addr, 16'd12);
        tick;
        chk("rd12_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
        chk("rd12_rdata", m0_rdata, 16'h0055);
        m0_req = 1'b0;
        #1;
        chk("rd13_gnt", {m0_gnt, m1_gnt}, 2'b01);
        chk("rd13_addr", mem_addr, 16'd13);
        tick;
        chk("rd13_rvalid", m1_rvalid, 1'b1);
        chk("rd13_rdata", m1_rdata, 16'h0D0D);
        m1_we = 1'b1; m1_addr = 16'd15; m1_wdata = 16'd200;
        #1;
        chk("wr_gnt", m1_gnt, 1'b1);
        chk("wr_strobes", {mem_write, mem_read}, 2'b10);
        chk("wr_addr", mem_addr, 16'd15);
        chk("wr_wdata", mem_wdata, 16'd200);
        tick;
        chk("wr_no_rvalid", {m1_rvalid, m1_err}, 2'b00);
        m1_we = 1'b0;
        #1;
        chk("rb_strobes", {m1_gnt, mem_read, mem_write}, 3'b110);
        tick;
        chk("rb_rvalid", m1_rvalid, 1'b1);
        chk("rb_rdata", m1_rdata, 16'd200);
        m0_req = 1'b1; m0_addr = 16'd1;
        m1_addr = 16'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick;
            chk("rr_rvalid", {m0_rvalid, m1_rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_rdata", (i % 2 == 0) ? m0_rdata : m1_rdata, (i % 2 == 0) ? 16'h0101 : 16'h0202);
        end
        m1_req = 1'b0; m0_addr = 16'd3;
        #1;
        chk("solo_gnt", {m0_gnt, m1_gnt}, 2'b10);
        tick;
        m0_addr = 16'd5;
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 16'd4;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("lock_gnt", {m0_gnt, m1_gnt}, 2'b01);
            tick;
            chk("lock_rdata", m1_rdata, 16'h0404);
        end
        #1;
        chk("lock_release_gnt", {m0_gnt, m1_gnt}, 2'b10);
        chk("lock_release_addr", mem_addr, 16'd5);
        tick;
        chk("lock_release_rdata", m0_rdata, 16'h0505);
        m1_req = 1'b0; m1_lock = 1'b0;
        m0_lock = 1'b1; m0_addr = 16'd6;
        tick;
        chk("pre_rst_rvalid", m0_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midlock_rst_rvalid", m0_rvalid, 1'b0);
        chk("midlock_rst_gnt", m0_gnt, 1'b0);
        tick;
        rst_n = 1'b1;
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_addr = 16'd7;
        #1;
        chk("post_rst_gnt", {m0_gnt, m1_gnt}, 2'b01);
        tick;
        chk("post_rst_rdata", m1_rdata, 16'h0707);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 16'd200;
        #1;
        chk("oor_rd_gnt", m0_gnt, 1'b1);
        chk("oor_rd_strobes", {mem_read, mem_write}, 2'b00);
        tick;
        chk("oor_rd_resp", {m0_err, m0_rvalid}, 2'b11);
        chk("oor_rd_rdata", m0_rdata, 16'h0000);
        m0_we = 1'b1; m0_addr = 16'd128; m0_wdata = 16'hBEEF;
        #1;
        chk("oor_wr_gnt", m0_gnt, 1'b1);
        chk("oor_wr_strobes", {mem_read, mem_write}, 2'b00);
        tick;
        chk("oor_wr_resp", {m0_err, m0_rvalid}, 2'b10);
        m0_req = 1'b0; m0_we = 1'b0;
        tick;
        chk("err_pulse_end", {m0_err, m1_err}, 2'b00);
        chk("mem0_intact", mem[0], 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
